lc3_execute: RTL and testbench
==============================

Name: lc3_execute

Overview:
- Execute stage of the LC-3 pipeline, directly downstream of decode.
- Consumes the decode outputs each enabled cycle: IR, npc, E_control, W_control and Mem_control.
- Performs the ALU operation or effective/branch address calculation, with operand bypass.
- Registers its results for writeback, memory access and branch control.

Parameters:
- DATA_W, 16, datapath width (IR, npc, operands, results).
- REG_AW, 3, register-file address width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_execute  in  1  stage advance; registers update only when 1.
- E_control  in  6  [5:4] alu_op, [3:2] pcselect1, [1] pcselect2, [0] op2select.
- W_control_in  in  2  writeback select, passed through.
- Mem_control_in  in  1  memory-access flag, passed through.
- IR  in  16  instruction from decode.
- npc  in  16  PC+1 from decode.
- VSR1, VSR2  in  16 each  register-file read data.
- bypass_alu_1, bypass_alu_2  in  1 each  use the registered aluout as operand 1 / 2.
- bypass_mem_1, bypass_mem_2  in  1 each  use Mem_Bypass_Val as operand 1 / 2.
- Mem_Bypass_Val  in  16  value forwarded from the memory stage.
- sr1, sr2  out  3 each  combinational register-file read addresses.
- aluout  out  16  registered result.
- pcout  out  16  registered address result.
- M_Data  out  16  registered store data.
- dr  out  3  registered destination register.
- NZP  out  3  registered branch condition mask.
- IR_Exec  out  16  registered copy of IR.
- W_control_out  out  2  registered pass-through of W_control_in.
- Mem_control_out  out  1  registered pass-through of Mem_control_in.

Behaviour:
- Reset: all registered outputs go to 0 immediately when reset=0, independent of clock. This includes a reset asserted mid-operation.
- Latency and hold: 1 cycle. Inputs sampled at the rising edge with enable_execute=1 appear on the outputs after that edge. With enable_execute=0, every registered output holds.
- sr1 = IR[8:6] for all opcodes.
- sr2 = IR[11:9] for ST/STR/STI (opcodes 0011/0111/1011); otherwise IR[2:0].
- Operand 1: if bypass_alu_1, current aluout; else if bypass_mem_1, Mem_Bypass_Val; else VSR1. ALU bypass wins when both bypasses are set.
- Register operand 2: same rule using the _2 signals and VSR2.
- ALU operand 2: if op2select=1, register operand 2; else sext(IR[4:0]). Bypass has no effect on an immediate.
- alu_op: 00 ADD (sum mod 2^16, no carry/overflow), 01 AND, 10 NOT (operand 1), 11 passes operand 1.
- Offset (pcselect1): 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 zero.
- Base (pcselect2): 1 npc, 0 operand 1 (bypassed).
- pcout = base + offset, mod 2^16; wrap-around is not flagged.
- aluout = ALU result for ADD/AND/NOT (0001/0101/1001); otherwise pcout.
- dr = IR[11:9] for ADD/AND/NOT/LD/LDR/LDI/LEA; otherwise 0.
- NZP = IR[11:9] for BR (0000), 111 for JMP (1100), 000 otherwise.
- M_Data = register operand 2 (bypassed) for ST/STR/STI; otherwise 0.
- IR_Exec, W_control_out and Mem_control_out are registered copies of their inputs.
- Unknown opcodes: aluout = pcout, dr=0, NZP=0, M_Data=0; no error signal.

Decomposition:
- Package lc3_pkg: opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_LD, OP_LDR, OP_LDI, OP_LEA, OP_ST, OP_STR, OP_STI), an alu_op enum, E_control field-index constants, and a sign-extend function.
- One sub-module lc3_execute_alu: combinational, taking operand 1, operand 2 and alu_op, producing a 16-bit result.
- The top level holds the operand muxes, address adder and pipeline registers.

Test Plan:
- ADD reg: IR=16'h1642, E_control=6'b000001, VSR1=5, VSR2=7, enable=1 → next cycle aluout=16'h000C, dr=3, sr1=1, sr2=2, NZP=0.
- ADD imm: IR=16'h14BF, E_control=6'b000000, VSR1=16'h0000 → aluout=16'hFFFF, dr=2.
- BRz: IR=16'h05FE, npc=16'h3005, E_control=6'b000110 → pcout=16'h3003, aluout=16'h3003, NZP=3'b010, dr=0.
- Bypass priority: following the ADD-reg case (aluout=16'h000C), issue IR=16'h5262 (AND) with bypass_alu_1=1, bypass_mem_1=1, Mem_Bypass_Val=16'h00AA, VSR2=16'h000F, E_control=6'b010001 → aluout=16'h000C. Repeat with bypass_mem_1 only → 16'h000A.
- STR: IR=16'h7A42, E_control=6'b001000, VSR1=16'h4000, VSR2=16'hBEEF → pcout=16'h4002, M_Data=16'hBEEF, sr2=5, dr=0, Mem_control_out follows its input.
- Stall and reset: hold enable_execute=0 for 3 cycles with changing inputs → outputs unchanged. Then drive reset=0 between clock edges → all outputs 0 immediately, and they stay 0 until the first enabled edge after reset=1.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 execute-stage definitions: opcodes, ALU operations, E_control
// field positions and a sign-extension helper.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;
    localparam int LC3_REG_AW = 3;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    localparam int EC_ALU_HI  = 5;
    localparam int EC_ALU_LO  = 4;
    localparam int EC_PCS1_HI = 3;
    localparam int EC_PCS1_LO = 2;
    localparam int EC_PCS2    = 1;
    localparam int EC_OP2SEL  = 0;

    // Sign-extends the low 'bits' bits of val to the full datapath width.
    function automatic logic [LC3_DATA_W-1:0] sext(input logic [LC3_DATA_W-1:0] val,
                                                   input int bits);
        logic signed [LC3_DATA_W-1:0] tmp;
        tmp = $signed(val << (LC3_DATA_W - bits));
        return tmp >>> (LC3_DATA_W - bits);
    endfunction

endpackage

// File: rtl/lc3_execute_alu.sv
// Combinational LC-3 ALU: ADD, AND, NOT of operand 1, or pass operand 1.
module lc3_execute_alu
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W
) (
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  alu_op_e           alu_op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = op1;
        case (alu_op)
            ALU_ADD:  result = op1 + op2;
            ALU_AND:  result = op1 & op2;
            ALU_NOT:  result = ~op1;
            ALU_PASS: result = op1;
            default:  result = op1;
        endcase
    end

endmodule

// File: rtl/lc3_execute.sv
// LC-3 execute stage: operand bypass muxes, ALU, address adder and the
// pipeline registers feeding memory, writeback and branch control.
module lc3_execute
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W,
    parameter int REG_AW = LC3_REG_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [5:0]        E_control,
    input  logic [1:0]        W_control_in,
    input  logic              Mem_control_in,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] VSR1,
    input  logic [DATA_W-1:0] VSR2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] Mem_Bypass_Val,
    output logic [REG_AW-1:0] sr1,
    output logic [REG_AW-1:0] sr2,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] pcout,
    output logic [DATA_W-1:0] M_Data,
    output logic [REG_AW-1:0] dr,
    output logic [2:0]        NZP,
    output logic [DATA_W-1:0] IR_Exec,
    output logic [1:0]        W_control_out,
    output logic              Mem_control_out
);

    // enable_execute is the only flow control: on a rising edge with it high
    // every register loads; with it low every register holds. No back-pressure.

    logic [3:0]        opcode;
    logic              is_store;
    logic              is_alu;
    logic              writes_dr;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] reg_op2;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] pc_sum;
    logic [DATA_W-1:0] aluout_d;
    logic [DATA_W-1:0] m_data_d;
    logic [REG_AW-1:0] dr_d;
    logic [2:0]        nzp_d;

    assign opcode    = IR[15:12];
    assign is_store  = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
    assign writes_dr = is_alu || (opcode == OP_LD) || (opcode == OP_LDR) ||
                       (opcode == OP_LDI) || (opcode == OP_LEA);

    // Stores read the source data register from the DR field.
    assign sr1 = IR[8:6];
    assign sr2 = is_store ? IR[11:9] : IR[2:0];

    // ALU forwarding wins over memory forwarding: it carries the younger result.
    assign op1     = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    assign reg_op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
    assign alu_op2 = E_control[EC_OP2SEL] ? reg_op2 : sext(DATA_W'(IR[4:0]), 5);

    lc3_execute_alu #(.DATA_W(DATA_W)) u_alu (
        .op1    (op1),
        .op2    (alu_op2),
        .alu_op (alu_op_e'(E_control[EC_ALU_HI:EC_ALU_LO])),
        .result (alu_result)
    );

    always_comb begin
        offset = '0;
        case (E_control[EC_PCS1_HI:EC_PCS1_LO])
            2'b00:   offset = sext(DATA_W'(IR[10:0]), 11);
            2'b01:   offset = sext(DATA_W'(IR[8:0]), 9);
            2'b10:   offset = sext(DATA_W'(IR[5:0]), 6);
            default: offset = '0;
        endcase
    end

    assign base   = E_control[EC_PCS2] ? npc : op1;
    assign pc_sum = base + offset;

    always_comb begin
        aluout_d = is_alu ? alu_result : pc_sum;
        m_data_d = is_store ? reg_op2 : '0;
        dr_d     = writes_dr ? IR[11:9] : '0;
        nzp_d    = 3'b000;
        if (opcode == OP_BR) begin
            nzp_d = IR[11:9];
        end else if (opcode == OP_JMP) begin
            nzp_d = 3'b111;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout          <= '0;
            pcout           <= '0;
            M_Data          <= '0;
            dr              <= '0;
            NZP             <= '0;
            IR_Exec         <= '0;
            W_control_out   <= '0;
            Mem_control_out <= 1'b0;
        end else if (enable_execute) begin
            aluout          <= aluout_d;
            pcout           <= pc_sum;
            M_Data          <= m_data_d;
            dr              <= dr_d;
            NZP             <= nzp_d;
            IR_Exec         <= IR;
            W_control_out   <= W_control_in;
            Mem_control_out <= Mem_control_in;
        end
    end

endmodule

// File: tb/tb_lc3_execute.sv
// Bench for lc3_execute: directed cases plus random traffic, checked by a
// queue-based scoreboard against a behavioural model of the execute rules.
module tb_lc3_execute;

    localparam int EXP_W = 73;

    logic        clock;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_control;
    logic [1:0]  W_control_in;
    logic        Mem_control_in;
    logic [15:0] IR;
    logic [15:0] npc;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [15:0] Mem_Bypass_Val;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [2:0]  dr;
    logic [2:0]  NZP;
    logic [15:0] IR_Exec;
    logic [1:0]  W_control_out;
    logic        Mem_control_out;

    lc3_execute dut (
        .clock           (clock),
        .reset           (reset),
        .enable_execute  (enable_execute),
        .E_control       (E_control),
        .W_control_in    (W_control_in),
        .Mem_control_in  (Mem_control_in),
        .IR              (IR),
        .npc             (npc),
        .VSR1            (VSR1),
        .VSR2            (VSR2),
        .bypass_alu_1    (bypass_alu_1),
        .bypass_alu_2    (bypass_alu_2),
        .bypass_mem_1    (bypass_mem_1),
        .bypass_mem_2    (bypass_mem_2),
        .Mem_Bypass_Val  (Mem_Bypass_Val),
        .sr1             (sr1),
        .sr2             (sr2),
        .aluout          (aluout),
        .pcout           (pcout),
        .M_Data          (M_Data),
        .dr              (dr),
        .NZP             (NZP),
        .IR_Exec         (IR_Exec),
        .W_control_out   (W_control_out),
        .Mem_control_out (Mem_control_out)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] held = '0;
    logic [15:0]      model_alu = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected packing: aluout, pcout, M_Data, IR_Exec, dr, NZP, W_control, Mem_control.
    function automatic logic [EXP_W-1:0] model(
        input logic [15:0] ir, input logic [15:0] pc1, input logic [5:0] ec,
        input logic [1:0] wc, input logic mc, input logic [15:0] v1, input logic [15:0] v2,
        input logic [3:0] byp, input logic [15:0] mbv, input logic [15:0] cur_alu);
        int op, o1, o2r, o2, off, base, pc, res, alu_v, mdata, d, z;
        op  = int'(ir[15:12]);
        o1  = byp[3] ? int'(cur_alu) : (byp[1] ? int'(mbv) : int'(v1));
        o2r = byp[2] ? int'(cur_alu) : (byp[0] ? int'(mbv) : int'(v2));
        o2  = ec[0] ? o2r : int'($signed(ir[4:0]));
        case (ec[3:2])
            2'd0:    off = int'($signed(ir[10:0]));
            2'd1:    off = int'($signed(ir[8:0]));
            2'd2:    off = int'($signed(ir[5:0]));
            default: off = 0;
        endcase
        base = ec[1] ? int'(pc1) : o1;
        pc   = (base + off) & 'hFFFF;
        case (ec[5:4])
            2'd0:    res = (o1 + o2) & 'hFFFF;
            2'd1:    res = o1 & o2 & 'hFFFF;
            2'd2:    res = ~o1 & 'hFFFF;
            default: res = o1;
        endcase
        alu_v = (op == 1 || op == 5 || op == 9) ? res : pc;
        mdata = (op == 3 || op == 7 || op == 11) ? o2r : 0;
        d = (op == 1 || op == 5 || op == 9 || op == 2 || op == 6 || op == 10 || op == 14)
            ? int'(ir[11:9]) : 0;
        z = (op == 0) ? int'(ir[11:9]) : ((op == 12) ? 7 : 0);
        return {16'(alu_v), 16'(pc), 16'(mdata), ir, 3'(d), 3'(z), wc, mc};
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic [15:0] ir, input logic [15:0] pc1, input logic [5:0] ec,
                         input logic [1:0] wc, input logic mc, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [3:0] byp, input logic [15:0] mbv,
                         input logic en);
        logic [EXP_W-1:0] e;
        int op;
        @(negedge clock);
        IR = ir; npc = pc1; E_control = ec; W_control_in = wc; Mem_control_in = mc;
        VSR1 = v1; VSR2 = v2; Mem_Bypass_Val = mbv; enable_execute = en;
        {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = byp;
        if (en && reset) begin
            e = model(ir, pc1, ec, wc, mc, v1, v2, byp, mbv, model_alu);
            exp_q.push_back(e);
            model_alu = e[72:57];
        end
        #1;
        op = int'(ir[15:12]);
        chk("sr1", 16'(sr1), 16'(ir[8:6]));
        chk("sr2", 16'(sr2), (op == 3 || op == 7 || op == 11) ? 16'(ir[11:9]) : 16'(ir[2:0]));
    endtask

    task automatic compare_all(input logic [EXP_W-1:0] e);
        chk("aluout", aluout, e[72:57]);
        chk("pcout", pcout, e[56:41]);
        chk("M_Data", M_Data, e[40:25]);
        chk("IR_Exec", IR_Exec, e[24:9]);
        chk("dr", 16'(dr), 16'(e[8:6]));
        chk("NZP", 16'(NZP), 16'(e[5:3]));
        chk("W_control_out", 16'(W_control_out), 16'(e[2:1]));
        chk("Mem_control_out", 16'(Mem_control_out), 16'(e[0]));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clock) begin
        logic en_s, rs_s;
        en_s = enable_execute;
        rs_s = reset;
        #1;
        if (!rs_s) begin
            held = '0;
        end else if (en_s) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: got output edge expected queued entry at %0t", $time);
            end else begin
                held = exp_q.pop_front();
            end
        end
        compare_all(held);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; enable_execute = 1'b0; E_control = '0; W_control_in = '0;
        Mem_control_in = 1'b0; IR = '0; npc = '0; VSR1 = '0; VSR2 = '0;
        bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
        Mem_Bypass_Val = '0;
        #2;
        chk("reset aluout", aluout, 16'h0000);
        chk("reset IR_Exec", IR_Exec, 16'h0000);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // ADD register form
        apply(16'h1642, 16'h3000, 6'b000001, 2'b01, 1'b0, 16'd5, 16'd7, 4'b0000, 16'h0, 1'b1);
        @(posedge clock); #2;
        chk("add_reg aluout", aluout, 16'h000C);
        chk("add_reg dr", 16'(dr), 16'd3);
        // Bypass priority: ALU wins over memory, then memory alone
        apply(16'h5262, 16'h3001, 6'b010001, 2'b01, 1'b0, 16'h1234, 16'h000F, 4'b1010, 16'h00AA, 1'b1);
        @(posedge clock); #2;
        chk("byp_both aluout", aluout, 16'h000C);
        apply(16'h5262, 16'h3002, 6'b010001, 2'b01, 1'b0, 16'h1234, 16'h000F, 4'b0010, 16'h00AA, 1'b1);
        @(posedge clock); #2;
        chk("byp_mem aluout", aluout, 16'h000A);
        // ADD immediate
        apply(16'h14BF, 16'h3003, 6'b000000, 2'b01, 1'b0, 16'h0000, 16'h5555, 4'b0000, 16'h0, 1'b1);
        @(posedge clock); #2;
        chk("add_imm aluout", aluout, 16'hFFFF);
        chk("add_imm dr", 16'(dr), 16'd2);
        // BRz backwards
        apply(16'h05FE, 16'h3005, 6'b000110, 2'b00, 1'b0, 16'h0, 16'h0, 4'b0000, 16'h0, 1'b1);
        @(posedge clock); #2;
        chk("brz pcout", pcout, 16'h3003);
        chk("brz NZP", 16'(NZP), 16'b010);
        chk("brz dr", 16'(dr), 16'd0);
        // STR
        apply(16'h7A42, 16'h3006, 6'b001000, 2'b00, 1'b1, 16'h4000, 16'hBEEF, 4'b0000, 16'h0, 1'b1);
        @(posedge clock); #2;
        chk("str pcout", pcout, 16'h4002);
        chk("str M_Data", M_Data, 16'hBEEF);
        chk("str Mem_control_out", 16'(Mem_control_out), 16'd1);

        // Stall with changing inputs: monitor checks the hold
        for (int i = 0; i < 3; i++) begin
            apply(16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 1'b0);
        end
        // Asynchronous reset between edges
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("async aluout", aluout, 16'h0000);
        chk("async pcout", pcout, 16'h0000);
        chk("async M_Data", M_Data, 16'h0000);
        chk("async IR_Exec", IR_Exec, 16'h0000);
        chk("async Mem_control_out", 16'(Mem_control_out), 16'd0);
        model_alu = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply(16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 1'b0);
        end
        @(posedge clock); #2;
        chk("post_reset aluout", aluout, 16'h0000);

        // Random traffic with stalls and bypasses
        for (int i = 0; i < 400; i++) begin
            apply(16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        @(negedge clock);
        enable_execute = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
